mult_share_ctrl: RTL
====================

MULT_SHARE_CTRL -- requirements
Module: mult_share_ctrl

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, 1, cycles allowed for multiplier settling after operand load (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req0  input  1  requester 0 operation request, held until gnt0.
REQ-005 SHALL have port: a0  input  4  requester 0 multiplicand.
REQ-006 SHALL have port: b0  input  4  requester 0 multiplier.
REQ-007 SHALL have port: req1  input  1  requester 1 operation request, held until gnt1.
REQ-008 SHALL have port: a1  input  4  requester 1 multiplicand.
REQ-009 SHALL have port: b1  input  4  requester 1 multiplier.
REQ-010 SHALL have port: gnt0 / gnt1  output  1 each  one-cycle grant pulse; operands sampled on that edge.
REQ-011 SHALL have port: done0 / done1  output  1 each  one-cycle result-valid pulse to granted requester.
REQ-012 SHALL have port: prod  output  8  registered unsigned product, held until next capture.
REQ-013 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, DONE; all outputs registered.
REQ-015 In IDLE, on an edge with any req high: load winner's a/b into operand registers, assert that gnt for the following cycle, clear settle counter, go SETTLE.
REQ-016 Arbitration SHALL be round-robin: single request wins; both high -> requester not granted last wins; last-grant pointer updated at each grant.
REQ-017 In SETTLE, counter SHALL increment each edge; on the edge where counter == SETTLE_CYCLES-1, prod captures multiplier output, done of granted requester asserts for next cycle, go DONE.
REQ-018 In DONE, next edge SHALL return to IDLE with done deasserted; requests are not sampled in DONE or SETTLE.
REQ-019 Timing: grant at edge k -> capture at edge k+SETTLE_CYCLES -> IDLE at k+SETTLE_CYCLES+1 -> earliest next grant at k+SETTLE_CYCLES+2.
REQ-020 Operands SHALL be stable in operand registers from grant edge through capture edge; a/b input changes after grant have no effect.
REQ-021 A req deasserted before its grant SHALL be treated as withdrawn; no grant, no done.
REQ-022 prod SHALL equal a*b unsigned, 8 bits, no truncation (max 15*15 = 225).
REQ-023 gnt0/gnt1 SHALL never be high together; done0/done1 likewise.

Reset
REQ-024 rst high SHALL immediately force state IDLE, gnt0=gnt1=0, done0=done1=0, busy=0, prod=8'h00, operand registers 0, counter 0, last-grant pointer = requester 1 (so requester 0 wins first contention).
REQ-025 Reset mid-operation SHALL discard the in-flight operation; no done is issued for it after release.
REQ-026 First grant after reset release SHALL occur no earlier than the first rising edge with rst low.

Structure
REQ-027 Shared package mult_ctrl_pkg SHALL hold the state enum, operand width (4), product width (8) and settle-counter width (4).
REQ-028 SHALL instantiate exactly one sub-module, the existing combinational 4x4 multiplier (module multiplier), with A0..A3/B0..B3 from operand register bits 0..3 and prod bits 0..6 from P0..P6, bit 7 from CC5.
REQ-029 No arithmetic SHALL be performed in the controller itself; the product comes only from the multiplier instance.

Verification
REQ-030 Single request: req0=1, a0=4'hF, b0=4'hF, SETTLE_CYCLES=1 -> gnt0 one cycle after sampling edge, done0 next cycle, prod=8'hE1.
REQ-031 Contention after reset: req0=req1=1 (a0=3,b0=5; a1=7,b1=9) -> gnt0 first with prod=8'h0F, then gnt1 with prod=8'h3F; gnt/done never overlap.
REQ-032 Round-robin fairness: both requests held continuously for 6 operations -> grants alternate 0,1,0,1,0,1.
REQ-033 Latency: SETTLE_CYCLES=4, req1 with a1=2,b1=6 -> done1 exactly 4 cycles after gnt1, prod=8'h0C, busy high from gnt through done.
REQ-034 Reset mid-op: assert rst during SETTLE -> all outputs 0 immediately, no done after release, next req0 with a0=1,b0=1 yields prod=8'h01.
REQ-035 Operand change after grant: a0 changed from 5 to 9 the cycle after gnt0 (b0=2) -> prod=8'h0A.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// rtl/mult_ctrl_pkg.sv - shared types and widths for the shared-multiplier controller
//
// Purpose: single home for the controller state encoding and the datapath
// widths used by the controller and its bench.
// Ports: none (package).

package mult_ctrl_pkg;

    localparam int OP_W   = 4;   // operand width
    localparam int PROD_W = 8;   // product width, wide enough for 15*15
    localparam int CNT_W  = 4;   // settle counter width, covers 1..15

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/multiplier.sv
// rtl/multiplier.sv - combinational 4x4 unsigned multiplier with bit-level ports
//
// Purpose: the shared multiplier core; pure combinational, no clock.
// Ports:
//   A0..A3  input  multiplicand bits, A0 is the LSB
//   B0..B3  input  multiplier bits, B0 is the LSB
//   P0..P6  output product bits 0..6
//   CC5     output product bit 7 (final carry of the adder array)

module multiplier (
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic B0,
    input  logic B1,
    input  logic B2,
    input  logic B3,
    output logic P0,
    output logic P1,
    output logic P2,
    output logic P3,
    output logic P4,
    output logic P5,
    output logic P6,
    output logic CC5
);

    logic [3:0] w_a;
    logic [3:0] w_b;
    logic [7:0] w_p;

    assign w_a = {A3, A2, A1, A0};
    assign w_b = {B3, B2, B1, B0};
    assign w_p = {4'd0, w_a} * {4'd0, w_b};

    assign P0  = w_p[0];
    assign P1  = w_p[1];
    assign P2  = w_p[2];
    assign P3  = w_p[3];
    assign P4  = w_p[4];
    assign P5  = w_p[5];
    assign P6  = w_p[6];
    assign CC5 = w_p[7];

endmodule

// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - two-requester round-robin controller for one shared multiplier
//
// Purpose: arbitrates two requesters onto a single combinational multiplier,
// holds the winner's operands while the multiplier settles, then captures
// the product and pulses done to the granted requester.
// Ports:
//   clk          input  rising-edge clock
//   rst          input  asynchronous active-high reset
//   req0/req1    input  operation requests, held until the matching grant
//   a0,b0/a1,b1  input  4-bit operands per requester
//   gnt0/gnt1    output one-cycle grant pulse (operands sampled on that edge)
//   done0/done1  output one-cycle result-valid pulse
//   prod         output registered 8-bit product, held until next capture
//   busy         output high whenever the controller is not idle
// Parameter:
//   SETTLE_CYCLES  cycles from grant edge to capture edge, legal 1..15

module mult_share_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [OP_W-1:0]   a0,
    input  logic [OP_W-1:0]   b0,
    input  logic              req1,
    input  logic [OP_W-1:0]   a1,
    input  logic [OP_W-1:0]   b1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [PROD_W-1:0] prod,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LP_LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    state_t              r_state, w_state;
    logic [OP_W-1:0]     r_a, w_a;
    logic [OP_W-1:0]     r_b, w_b;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic                r_last, w_last;    // 1: requester 1 was granted last
    logic                r_owner, w_owner;  // requester owning the in-flight op
    logic                r_gnt0, w_gnt0;
    logic                r_gnt1, w_gnt1;
    logic                r_done0, w_done0;
    logic                r_done1, w_done1;
    logic [PROD_W-1:0]   r_prod, w_prod;
    logic                r_busy, w_busy;
    logic                w_pick1;
    logic [PROD_W-1:0]   w_mul;

    // Requester 1 wins when it is alone, or when both request and
    // requester 0 had the previous grant.
    assign w_pick1 = req1 & (~req0 | ~r_last);

    multiplier u_mult (
        .A0  (r_a[0]),
        .A1  (r_a[1]),
        .A2  (r_a[2]),
        .A3  (r_a[3]),
        .B0  (r_b[0]),
        .B1  (r_b[1]),
        .B2  (r_b[2]),
        .B3  (r_b[3]),
        .P0  (w_mul[0]),
        .P1  (w_mul[1]),
        .P2  (w_mul[2]),
        .P3  (w_mul[3]),
        .P4  (w_mul[4]),
        .P5  (w_mul[5]),
        .P6  (w_mul[6]),
        .CC5 (w_mul[7])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_prod  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_a     <= w_a;
            r_b     <= w_b;
            r_cnt   <= w_cnt;
            r_last  <= w_last;
            r_owner <= w_owner;
            r_gnt0  <= w_gnt0;
            r_gnt1  <= w_gnt1;
            r_done0 <= w_done0;
            r_done1 <= w_done1;
            r_prod  <= w_prod;
            r_busy  <= w_busy;
        end
    end

    always_comb begin
        w_state = r_state;
        w_a     = r_a;
        w_b     = r_b;
        w_cnt   = r_cnt;
        w_last  = r_last;
        w_owner = r_owner;
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        w_done0 = 1'b0;
        w_done1 = 1'b0;
        w_prod  = r_prod;

        case (r_state)
            ST_IDLE: begin
                if (req0 | req1) begin
                    w_owner = w_pick1;
                    w_last  = w_pick1;
                    w_a     = w_pick1 ? a1 : a0;
                    w_b     = w_pick1 ? b1 : b0;
                    w_gnt0  = ~w_pick1;
                    w_gnt1  = w_pick1;
                    w_cnt   = '0;
                    w_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == LP_LAST_CNT) begin
                    w_prod  = w_mul;
                    w_done0 = ~r_owner;
                    w_done1 = r_owner;
                    w_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    assign gnt0  = r_gnt0;
    assign gnt1  = r_gnt1;
    assign done0 = r_done0;
    assign done1 = r_done1;
    assign prod  = r_prod;
    assign busy  = r_busy;

endmodule
